// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: op classes, forwarding select codes,
// MUL/DIV stall FSM state encoding and a small helper function.
// Optional perf counters in the top are enabled with the HAZARD_PERF_CNT_EN macro.
package hazard_pkg;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_ALU    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_STORE  = 3'd3,
        OP_MULDIV = 3'd4
    } optype_e;

    localparam logic [1:0] FWD_RF       = 2'b00;
    localparam logic [1:0] FWD_EX       = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU  = 2'b10;
    localparam logic [1:0] FWD_MEM_LOAD = 2'b11;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } mdState_e;

    // Op classes that write a destination register and can therefore be a hazard source.
    function automatic logic writesReg(input optype_e op);
        return (op == OP_ALU) || (op == OP_LOAD) || (op == OP_MULDIV);
    endfunction

endpackage

// File: rtl/muldiv_stall_fsm.sv
// Multi-cycle MUL/DIV stall FSM. A start pulse (MUL/DIV entering EX) moves it to BUSY
// for MULDIV_LAT-1 cycles; with MULDIV_LAT=1 it never leaves IDLE.
module muldiv_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic busy_o
);

    localparam int CW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);
    localparam logic MULTI_CYCLE = (MULDIV_LAT > 1);

    mdState_e        state_q;
    logic [CW-1:0]   cnt_q;

    // State and latency counter: load LAT-2 on start, leave BUSY once the counter has reached zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i && MULTI_CYCLE) begin
                        state_q <= MD_BUSY;
                        cnt_q   <= LOAD_VAL;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= MD_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage core: tracks op class and rd of the EX and MEM
// instructions, produces rs1/rs2 forwarding selects, load->store data forwarding,
// load-use and MUL/DIV stalls, branch flush and stage enables.
// Define HAZARD_PERF_CNT_EN to build the saturating perf counters; otherwise the
// perf ports are tied to zero.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        optype_id,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              rs1_use,
    input  logic              rs2_use,
    input  logic [REG_AW-1:0] rd_id,
    input  logic              branch_id,
    output logic              pc_en,
    output logic              fd_en,
    output logic              de_en,
    output logic              em_en,
    output logic              mw_en,
    output logic              fd_flush,
    output logic              de_flush,
    output logic              em_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_ls,
    output logic              muldiv_busy,
    output logic [CNT_W-1:0]  perf_load_stall,
    output logic [CNT_W-1:0]  perf_muldiv_stall,
    output logic [CNT_W-1:0]  perf_flush
);

    optype_e           exOp_q, exOp_d, memOp_q, memOp_d;
    logic [REG_AW-1:0] exRd_q, exRd_d, exRs2_q, exRs2_d, memRd_q, memRd_d;

    optype_e idOp;
    logic    busy, loadUse, mdStart;
    logic    rs1Ex, rs2Ex, rs1Mem, rs2Mem;

    // A source operand depends on a stage when it is read, names that stage's non-x0 rd,
    // and the stage holds a register-writing op.
    function automatic logic srcMatch(input logic rdUsed, input logic [REG_AW-1:0] rs,
                                      input optype_e op, input logic [REG_AW-1:0] rd);
        return rdUsed && (rs == rd) && (rd != '0) && writesReg(op);
    endfunction

    // Nearest ready producer wins; a load still in EX has no data yet and cannot forward.
    function automatic logic [1:0] fwdSel(input logic exHit, input logic memHit,
                                          input optype_e exOp, input optype_e memOp);
        if (exHit && (exOp != OP_LOAD))        return FWD_EX;
        else if (memHit && (memOp != OP_LOAD)) return FWD_MEM_ALU;
        else if (memHit)                       return FWD_MEM_LOAD;
        else                                   return FWD_RF;
    endfunction

    assign idOp   = optype_e'(optype_id);
    assign rs1Ex  = srcMatch(rs1_use, rs1_id, exOp_q, exRd_q);
    assign rs2Ex  = srcMatch(rs2_use, rs2_id, exOp_q, exRd_q);
    assign rs1Mem = srcMatch(rs1_use, rs1_id, memOp_q, memRd_q);
    assign rs2Mem = srcMatch(rs2_use, rs2_id, memOp_q, memRd_q);

    assign fwd_a  = fwdSel(rs1Ex, rs1Mem, exOp_q, memOp_q);
    assign fwd_b  = fwdSel(rs2Ex, rs2Mem, exOp_q, memOp_q);
    assign fwd_ls = (exOp_q == OP_STORE) && (memOp_q == OP_LOAD) &&
                    (exRs2_q == memRd_q) && (memRd_q != '0);

    // A store's rs2 is only needed in MEM, so it is served by fwd_ls instead of stalling.
    assign loadUse = !busy && (exOp_q == OP_LOAD) &&
                     (rs1Ex || (rs2Ex && (idOp != OP_STORE)));

    assign pc_en       = !(busy || loadUse);
    assign fd_en       = !(busy || loadUse);
    assign de_en       = !busy;
    assign em_en       = 1'b1;
    assign mw_en       = 1'b1;
    assign fd_flush    = branch_id && !busy && !loadUse;
    assign de_flush    = loadUse;
    assign em_flush    = busy;
    assign muldiv_busy = busy;

    assign mdStart = de_en && !de_flush && (idOp == OP_MULDIV);

    muldiv_stall_fsm #(
        .MULDIV_LAT(MULDIV_LAT)
    ) uMuldivFsm (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(mdStart),
        .busy_o (busy)
    );

    // Next contents of the EX and MEM tracking slots: EX holds while stalled, bubbles on flush.
    always_comb begin
        exOp_d  = exOp_q;
        exRd_d  = exRd_q;
        exRs2_d = exRs2_q;
        if (de_en) begin
            if (de_flush) begin
                exOp_d  = OP_NONE;
                exRd_d  = '0;
                exRs2_d = '0;
            end else begin
                exOp_d  = idOp;
                exRd_d  = rd_id;
                exRs2_d = rs2_id;
            end
        end
        memOp_d = em_flush ? OP_NONE : exOp_q;
        memRd_d = em_flush ? '0 : exRd_q;
    end

    // Tracking slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exOp_q  <= OP_NONE;
            exRd_q  <= '0;
            exRs2_q <= '0;
            memOp_q <= OP_NONE;
            memRd_q <= '0;
        end else begin
            exOp_q  <= exOp_d;
            exRd_q  <= exRd_d;
            exRs2_q <= exRs2_d;
            memOp_q <= memOp_d;
            memRd_q <= memRd_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perfLs_q, perfMd_q, perfFl_q;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? (v + CNT_W'(1)) : v;
    endfunction

    // Saturating event counters for load-use stalls, MUL/DIV busy cycles and branch flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfLs_q <= '0;
            perfMd_q <= '0;
            perfFl_q <= '0;
        end else begin
            perfLs_q <= satInc(perfLs_q, loadUse);
            perfMd_q <= satInc(perfMd_q, busy);
            perfFl_q <= satInc(perfFl_q, fd_flush);
        end
    end

    assign perf_load_stall   = perfLs_q;
    assign perf_muldiv_stall = perfMd_q;
    assign perf_flush        = perfFl_q;
`else
    assign perf_load_stall   = '0;
    assign perf_muldiv_stall = '0;
    assign perf_flush        = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed scenarios with literal expectations followed
// by randomized ID-stage traffic checked every cycle against an in-flight instruction model.
module tb_hazard_scoreboard;

    localparam int LAT   = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam int NONE = 0, ALU = 1, LOAD = 2, STORE = 3, MULDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  optypeId = '0;
    logic [4:0]  rs1Id = '0, rs2Id = '0, rdId = '0;
    logic        rs1Use = 1'b0, rs2Use = 1'b0, branchId = 1'b0;

    logic        pcEn, fdEn, deEn, emEn, mwEn, fdFlush, deFlush, emFlush, fwdLs, busy;
    logic [1:0]  fwdA, fwdB;
    logic [CNT_W-1:0] perfLs, perfMd, perfFl;

    int checkCount = 0;
    int errorCount = 0;
    bit cmpEn = 1'b0;

    hazard_scoreboard #(
        .REG_AW(5), .MULDIV_LAT(LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .optype_id(optypeId), .rs1_id(rs1Id), .rs2_id(rs2Id),
        .rs1_use(rs1Use), .rs2_use(rs2Use), .rd_id(rdId), .branch_id(branchId),
        .pc_en(pcEn), .fd_en(fdEn), .de_en(deEn), .em_en(emEn), .mw_en(mwEn),
        .fd_flush(fdFlush), .de_flush(deFlush), .em_flush(emFlush),
        .fwd_a(fwdA), .fwd_b(fwdB), .fwd_ls(fwdLs), .muldiv_busy(busy),
        .perf_load_stall(perfLs), .perf_muldiv_stall(perfMd), .perf_flush(perfFl)
    );

    always #5 clk = ~clk;

    // Model: each pipeline slot is an instruction record; a MUL/DIV carries its remaining EX cycles.
    typedef struct { int op; int rd; int rs2; } slot_t;
    typedef struct { int pcEn, fdEn, deEn, fdFlush, deFlush, emFlush, fwdA, fwdB, fwdLs, busy, ls; } exp_t;

    slot_t exS  = '{NONE, 0, 0};
    slot_t memS = '{NONE, 0, 0};
    int exLeft = 0;
    int cntLs = 0, cntMd = 0, cntFl = 0;

    function automatic bit hits(slot_t s, int rs, bit used);
        return used && rs != 0 && s.rd == rs && (s.op == ALU || s.op == LOAD || s.op == MULDIV);
    endfunction

    function automatic int fwdOf(int rs, bit used);
        if (hits(exS, rs, used) && exS.op != LOAD) return 1;
        if (hits(memS, rs, used) && memS.op != LOAD) return 2;
        if (hits(memS, rs, used)) return 3;
        return 0;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        e.busy    = (exLeft > 0);
        e.ls      = !e.busy && exS.op == LOAD &&
                    (hits(exS, int'(rs1Id), rs1Use) ||
                     (hits(exS, int'(rs2Id), rs2Use) && int'(optypeId) != STORE));
        e.pcEn    = !(e.busy || e.ls);
        e.fdEn    = e.pcEn;
        e.deEn    = !e.busy;
        e.fdFlush = branchId && !e.busy && !e.ls;
        e.deFlush = e.ls;
        e.emFlush = e.busy;
        e.fwdA    = fwdOf(int'(rs1Id), rs1Use);
        e.fwdB    = fwdOf(int'(rs2Id), rs2Use);
        e.fwdLs   = exS.op == STORE && memS.op == LOAD && exS.rs2 == memS.rd && memS.rd != 0;
        return e;
    endfunction

    function automatic int sat(int v, int inc);
        return (v + inc > CMAX) ? CMAX : v + inc;
    endfunction

    // Advance the model one clock; asynchronous reset empties the pipeline.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exS = '{NONE, 0, 0}; memS = '{NONE, 0, 0}; exLeft = 0;
            cntLs = 0; cntMd = 0; cntFl = 0;
        end else begin
            exp_t e;
            e = predict();
            cntLs = sat(cntLs, e.ls);
            cntMd = sat(cntMd, e.busy);
            cntFl = sat(cntFl, e.fdFlush);
            if (e.busy) begin
                exLeft = exLeft - 1;
                memS = '{NONE, 0, 0};
            end else begin
                memS = exS;
                if (e.ls) begin
                    exS = '{NONE, 0, 0};
                    exLeft = 0;
                end else begin
                    exS = '{int'(optypeId), int'(rdId), int'(rs2Id)};
                    exLeft = (int'(optypeId) == MULDIV) ? LAT - 1 : 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checkCount++;
        if (act !== expv) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            exp_t e;
            int pl, pm, pf;
            e = predict();
`ifdef HAZARD_PERF_CNT_EN
            pl = cntLs; pm = cntMd; pf = cntFl;
`else
            pl = 0; pm = 0; pf = 0;
`endif
            checkOutput("pc_en", 32'(pcEn), 32'(e.pcEn));
            checkOutput("fd_en", 32'(fdEn), 32'(e.fdEn));
            checkOutput("de_en", 32'(deEn), 32'(e.deEn));
            checkOutput("em_en", 32'(emEn), 32'd1);
            checkOutput("mw_en", 32'(mwEn), 32'd1);
            checkOutput("fd_flush", 32'(fdFlush), 32'(e.fdFlush));
            checkOutput("de_flush", 32'(deFlush), 32'(e.deFlush));
            checkOutput("em_flush", 32'(emFlush), 32'(e.emFlush));
            checkOutput("fwd_a", 32'(fwdA), 32'(e.fwdA));
            checkOutput("fwd_b", 32'(fwdB), 32'(e.fwdB));
            checkOutput("fwd_ls", 32'(fwdLs), 32'(e.fwdLs));
            checkOutput("muldiv_busy", 32'(busy), 32'(e.busy));
            checkOutput("perf_load_stall", 32'(perfLs), 32'(pl));
            checkOutput("perf_muldiv_stall", 32'(perfMd), 32'(pm));
            checkOutput("perf_flush", 32'(perfFl), 32'(pf));
        end
    end

    task automatic applyStimulus(input int op, input int r1, input bit u1, input int r2,
                                 input bit u2, input int rd, input bit br);
        optypeId = 3'(op);
        rs1Id    = 5'(r1);
        rs1Use   = u1;
        rs2Id    = 5'(r2);
        rs2Use   = u2;
        rdId     = 5'(rd);
        branchId = br;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        applyStimulus(NONE, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    int expLs1;

    initial begin
        $display("[TB] start");
        applyStimulus(NONE, 0, 0, 0, 0, 0, 0);
        step();
        step();
        #1 checkOutput("reset_pc_en", 32'(pcEn), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_fwd_a", 32'(fwdA), 32'd0);
        rst_n = 1'b1;
        cmpEn = 1'b1;
        step();

        // ALU producer in EX then MEM
        applyStimulus(ALU, 0, 0, 0, 0, 5, 0); step();
        applyStimulus(ALU, 5, 1, 6, 1, 6, 0); #2;
        checkOutput("t1_fwd_a_ex", 32'(fwdA), 32'd1);
        checkOutput("t1_fwd_b", 32'(fwdB), 32'd0);
        checkOutput("t1_pc_en", 32'(pcEn), 32'd1);
        step();
        applyStimulus(ALU, 5, 1, 0, 0, 7, 0); #2;
        checkOutput("t1_fwd_a_mem", 32'(fwdA), 32'd2);
        step(); nop(); nop();

        // Both operands from the same EX producer; x0 never forwards
        applyStimulus(ALU, 0, 0, 0, 0, 5, 0); step();
        applyStimulus(ALU, 5, 1, 5, 1, 6, 0); #2;
        checkOutput("t2_fwd_a", 32'(fwdA), 32'd1);
        checkOutput("t2_fwd_b", 32'(fwdB), 32'd1);
        step();
        applyStimulus(ALU, 0, 0, 0, 0, 0, 0); step();
        applyStimulus(ALU, 0, 1, 0, 0, 7, 0); #2;
        checkOutput("t2_fwd_a_x0", 32'(fwdA), 32'd0);
        step(); nop(); nop();

        // Load-use stall for one cycle, then load-data forward
        applyStimulus(LOAD, 0, 0, 0, 0, 6, 0); step();
        applyStimulus(ALU, 6, 1, 0, 0, 7, 0); #2;
        checkOutput("t3_pc_en", 32'(pcEn), 32'd0);
        checkOutput("t3_fd_en", 32'(fdEn), 32'd0);
        checkOutput("t3_de_flush", 32'(deFlush), 32'd1);
        checkOutput("t3_de_en", 32'(deEn), 32'd1);
        step(); #2;
        checkOutput("t3_pc_en_after", 32'(pcEn), 32'd1);
        checkOutput("t3_fwd_a", 32'(fwdA), 32'd3);
`ifdef HAZARD_PERF_CNT_EN
        expLs1 = 1;
`else
        expLs1 = 0;
`endif
        checkOutput("t3_perf_load_stall", 32'(perfLs), 32'(expLs1));
        step(); nop(); nop();

        // Load followed by dependent store: no stall, store data forwarded in EX
        applyStimulus(LOAD, 0, 0, 0, 0, 7, 0); step();
        applyStimulus(STORE, 1, 1, 7, 1, 0, 0); #2;
        checkOutput("t4_pc_en", 32'(pcEn), 32'd1);
        checkOutput("t4_de_flush", 32'(deFlush), 32'd0);
        step();
        applyStimulus(NONE, 0, 0, 0, 0, 0, 0); #2;
        checkOutput("t4_fwd_ls", 32'(fwdLs), 32'd1);
        step(); nop();

        // MUL/DIV: three busy cycles, then EX forward
        applyStimulus(MULDIV, 0, 0, 0, 0, 8, 0); step();
        applyStimulus(ALU, 8, 1, 0, 0, 9, 0);
        for (int i = 0; i < 3; i++) begin
            #2;
            checkOutput("t5_busy", 32'(busy), 32'd1);
            checkOutput("t5_em_flush", 32'(emFlush), 32'd1);
            checkOutput("t5_pc_en", 32'(pcEn), 32'd0);
            step();
        end
        #2;
        checkOutput("t5_busy_done", 32'(busy), 32'd0);
        checkOutput("t5_fwd_a", 32'(fwdA), 32'd1);
        checkOutput("t5_pc_en_done", 32'(pcEn), 32'd1);
        step(); nop(); nop();

        // Branch held during load-use stall, then taken
        applyStimulus(LOAD, 0, 0, 0, 0, 6, 0); step();
        applyStimulus(ALU, 6, 1, 0, 0, 7, 1); #2;
        checkOutput("t6_fd_flush_stall", 32'(fdFlush), 32'd0);
        step(); #2;
        checkOutput("t6_fd_flush", 32'(fdFlush), 32'd1);
        step(); nop();

        // Asynchronous reset in the middle of BUSY
        applyStimulus(MULDIV, 0, 0, 0, 0, 8, 0); step();
        applyStimulus(NONE, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("t6_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0; #1;
        checkOutput("t6_busy_reset", 32'(busy), 32'd0);
        checkOutput("t6_pc_en_reset", 32'(pcEn), 32'd1);
        checkOutput("t6_em_flush_reset", 32'(emFlush), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Randomized ID-stage traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                applyStimulus(NONE, 0, 0, 0, 0, 0, 0);
                rst_n = 1'b0;
            end
            if (rst_n) begin
                int r, op;
                r = $urandom_range(0, 15);
                op = (r < 3) ? NONE : (r < 8) ? ALU : (r < 11) ? LOAD : (r < 14) ? STORE : MULDIV;
                applyStimulus(op, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                              $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                              $urandom_range(0, 3), 1'($urandom_range(0, 5) == 0));
            end
            step();
        end

        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
